nes_clken_gen: RTL and testbench

NES_CLKEN_GEN -- requirements
Module: nes_clken_gen

---
 rtl/nes_clken_gen_pkg.sv | 20 ++
 rtl/nes_clken_gen_phase_acc.sv | 42 ++++
 rtl/nes_clken_gen.sv | 96 +++++++++
 tb/tb_nes_clken_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_clken_gen_pkg.sv
// nes_clken_gen_pkg: shared FSM encoding, default parameters and helpers for the clock-enable generator.
package nes_clken_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_ACC_WIDTH   = 24;
  localparam int DEF_LOCK_CYCLES = 16;
  localparam int DEF_RST_HOLD    = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_clken_gen_phase_acc.sv
// nes_phase_acc: one phase-accumulator channel producing a registered carry strobe and MSB level.
module nes_phase_acc #(
  parameter int                   ACC_WIDTH = 24,
  parameter logic [ACC_WIDTH-1:0] INIT_INC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 wr_i,
  input  logic [ACC_WIDTH-1:0] inc_i,
  input  logic [ACC_WIDTH-1:0] phase_i,
  output logic                 carry_o,
  output logic                 lvl_o
);
  logic [ACC_WIDTH-1:0] acc_q, inc_q;
  logic                 carry_q, lvl_q;
  logic [ACC_WIDTH:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  // A configuration write overrides the add, so an overflow on that cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      inc_q   <= INIT_INC;
      carry_q <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      if (wr_i) begin
        acc_q <= phase_i;
        inc_q <= inc_i;
      end else if (en_i) begin
        acc_q <= sum[ACC_WIDTH-1:0];
      end
      carry_q <= en_i & ~wr_i & sum[ACC_WIDTH];
      if (en_i) lvl_q <= acc_q[ACC_WIDTH-1];
    end
  end

  assign carry_o = carry_q;
  assign lvl_o   = lvl_q;
endmodule

// File: rtl/nes_clken_gen.sv
// nes_clken_gen: multi-channel phase-accumulator clock-enable generator with lock and downstream reset sequencing.
module nes_clken_gen
  import nes_clken_gen_pkg::*;
#(
  parameter int                   NUM_CH      = DEF_NUM_CH,
  parameter int                   ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int                   LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int                   RST_HOLD    = DEF_RST_HOLD,
  parameter logic [ACC_WIDTH-1:0] INIT_INC    = '0,
  localparam int                  CH_W        = $clog2(NUM_CH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_wr,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic [ACC_WIDTH-1:0] cfg_phase,
  input  logic [NUM_CH-1:0]    ch_en,
  output logic [NUM_CH-1:0]    ce_out,
  output logic [NUM_CH-1:0]    clk_lvl,
  output logic                 locked,
  output logic                 out_rst_n
);
  localparam int              CNT_W     = $clog2(max_int(LOCK_CYCLES, RST_HOLD) + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               locked_q, out_rst_n_q;
  logic               cfg_ok;
  logic [NUM_CH-1:0]  carry;

  // cfg_ch carries one spare code so out-of-range writes can be expressed and discarded.
  assign cfg_ok = cfg_wr && (cfg_ch < CH_W'(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      locked_q    <= 1'b0;
      out_rst_n_q <= 1'b0;
    end else if (cfg_ok) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= '0;
      locked_q    <= 1'b0;
      out_rst_n_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_SETTLE;
          cnt_q   <= '0;
        end
        ST_SETTLE: begin
          if (cnt_q == LOCK_LAST) begin
            state_q  <= ST_HOLD;
            cnt_q    <= '0;
            locked_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q     <= ST_RUN;
            out_rst_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: state_q <= ST_RUN;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nes_phase_acc #(
      .ACC_WIDTH (ACC_WIDTH),
      .INIT_INC  (INIT_INC)
    ) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (ch_en[i]),
      .wr_i    (cfg_ok && (cfg_ch == CH_W'(i))),
      .inc_i   (cfg_inc),
      .phase_i (cfg_phase),
      .carry_o (carry[i]),
      .lvl_o   (clk_lvl[i])
    );
  end

  assign ce_out    = carry & {NUM_CH{locked_q}};
  assign locked    = locked_q;
  assign out_rst_n = out_rst_n_q;
endmodule

// File: tb/tb_nes_clken_gen.sv
// tb_nes_clken_gen: randomized and directed checks of nes_clken_gen against a cycle-level behavioural model.
module tb_nes_clken_gen;
  localparam int LC = 4;
  localparam int RH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_inc = '0;
  logic [7:0] cfg_phase = '0;
  logic [1:0] ch_en = 2'b11;
  logic [1:0] ce_out, clk_lvl;
  logic       locked, out_rst_n;

  int m_acc [2];
  int m_inc [2];
  bit m_carry [2];
  bit m_lvl [2];
  int edge_n = 0;
  int lock_at = 1 << 30;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nes_clken_gen #(
    .NUM_CH      (2),
    .ACC_WIDTH   (8),
    .LOCK_CYCLES (LC),
    .RST_HOLD    (RH),
    .INIT_INC    (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .ch_en     (ch_en),
    .ce_out    (ce_out),
    .clk_lvl   (clk_lvl),
    .locked    (locked),
    .out_rst_n (out_rst_n)
  );

  // Model: lock happens LC edges after the edge that starts settling (the IDLE edge or a valid write).
  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_inc[i] = 0; m_carry[i] = 0; m_lvl[i] = 0;
      end
      lock_at = edge_n + 1 + LC;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cfg_wr && int'(cfg_ch) == i) begin
          if (ch_en[i]) m_lvl[i] = m_acc[i] >= 128;
          m_acc[i] = int'(cfg_phase);
          m_inc[i] = int'(cfg_inc);
          m_carry[i] = 0;
        end else if (ch_en[i]) begin
          m_lvl[i] = m_acc[i] >= 128;
          m_carry[i] = (m_acc[i] + m_inc[i]) >= 256;
          m_acc[i] = (m_acc[i] + m_inc[i]) % 256;
        end else begin
          m_carry[i] = 0;
        end
      end
      if (cfg_wr && cfg_ch < 2) lock_at = edge_n + LC;
    end
    #1;
  endtask

  function automatic logic [5:0] expv();
    bit lk = edge_n >= lock_at;
    return {m_carry[1] & lk, m_carry[0] & lk, m_lvl[1], m_lvl[0], lk, edge_n >= lock_at + RH};
  endfunction

  task automatic write(input logic [1:0] ch, input logic [7:0] inc, input logic [7:0] ph);
    cfg_wr = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_phase = ph;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    int rel, first_lock, first_run;
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({ce_out, clk_lvl, locked, out_rst_n} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 000000", {ce_out, clk_lvl, locked, out_rst_n});
    end
    rst_n = 1'b1;
    rel = edge_n; first_lock = -1; first_run = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if ({ce_out, clk_lvl, locked, out_rst_n} !== expv()) begin
        n_fail++;
        $display("FAIL reset_seq edge %0d: got %b want %b", edge_n, {ce_out, clk_lvl, locked, out_rst_n}, expv());
      end
      if (locked && first_lock < 0) first_lock = edge_n - rel;
      if (out_rst_n && first_run < 0) first_run = edge_n - rel;
    end
    n_cmp++;
    if (first_lock != LC + 1 || first_run != LC + 1 + RH) begin
      n_fail++;
      $display("FAIL reset_timing: lock %0d run %0d want %0d %0d", first_lock, first_run, LC + 1, LC + 1 + RH);
    end
  endtask

  task automatic test_square();
    int c0, c1, tog;
    logic prev;
    write(2'd0, 8'h80, 8'h00);
    write(2'd1, 8'h40, 8'h00);
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if ({ce_out, clk_lvl, locked, out_rst_n} !== expv()) begin
        n_fail++;
        $display("FAIL square edge %0d: got %b want %b", edge_n, {ce_out, clk_lvl, locked, out_rst_n}, expv());
      end
    end
    c0 = 0; c1 = 0; tog = 0; prev = clk_lvl[0];
    for (int k = 0; k < 8; k++) begin
      tick();
      c0 += int'(ce_out[0]); c1 += int'(ce_out[1]);
      tog += int'(clk_lvl[0] != prev); prev = clk_lvl[0];
    end
    n_cmp++;
    if (c0 != 4 || c1 != 2 || tog != 8) begin
      n_fail++;
      $display("FAIL square_rate: ce0 %0d ce1 %0d toggles %0d want 4 2 8", c0, c1, tog);
    end
  endtask

  task automatic test_phase();
    int e, f0, f1;
    e = edge_n + 1;
    write(2'd0, 8'h40, 8'h00);
    write(2'd1, 8'h40, 8'hC0);
    f0 = -1; f1 = -1;
    for (int k = 0; k < 14; k++) begin
      tick();
      n_cmp++;
      if ({ce_out, clk_lvl, locked, out_rst_n} !== expv()) begin
        n_fail++;
        $display("FAIL phase edge %0d: got %b want %b", edge_n, {ce_out, clk_lvl, locked, out_rst_n}, expv());
      end
      if (ce_out[0] && f0 < 0) f0 = edge_n - e;
      if (ce_out[1] && f1 < 0) f1 = edge_n - e;
    end
    n_cmp++;
    if (f0 != 8 || f1 != 6) begin
      n_fail++;
      $display("FAIL phase_offset: first ce0 %0d ce1 %0d want 8 6", f0, f1);
    end
  endtask

  task automatic test_rate();
    int c0;
    write(2'd0, 8'h55, 8'h00);
    repeat (6) tick();
    c0 = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      c0 += int'(ce_out[0]);
      n_cmp++;
      if ({ce_out, clk_lvl, locked, out_rst_n} !== expv()) begin
        n_fail++;
        $display("FAIL rate edge %0d: got %b want %b", edge_n, {ce_out, clk_lvl, locked, out_rst_n}, expv());
      end
    end
    n_cmp++;
    if (c0 != 85) begin
      n_fail++;
      $display("FAIL rate_count: got %0d want 85", c0);
    end
  endtask

  task automatic test_enable();
    logic held;
    held = clk_lvl[1];
    ch_en = 2'b01;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (ce_out[1] !== 1'b0 || clk_lvl[1] !== held || {ce_out, clk_lvl, locked, out_rst_n} !== expv()) begin
        n_fail++;
        $display("FAIL enable_off edge %0d: got %b want %b lvl1 held %b", edge_n, {ce_out, clk_lvl, locked, out_rst_n}, expv(), held);
      end
    end
    ch_en = 2'b11;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if ({ce_out, clk_lvl, locked, out_rst_n} !== expv()) begin
        n_fail++;
        $display("FAIL enable_resume edge %0d: got %b want %b", edge_n, {ce_out, clk_lvl, locked, out_rst_n}, expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    int w, fl, fr, guard;
    guard = 0;
    while (!out_rst_n && guard < 20) begin tick(); guard++; end
    n_cmp++;
    if (!out_rst_n) begin
      n_fail++;
      $display("FAIL run_wait: out_rst_n %b want 1 within 20 cycles", out_rst_n);
    end
    write(2'd3, 8'hFF, 8'hFF);
    n_cmp++;
    if ({locked, out_rst_n} !== 2'b11 || {ce_out, clk_lvl, locked, out_rst_n} !== expv()) begin
      n_fail++;
      $display("FAIL invalid_ch: got %b want %b", {ce_out, clk_lvl, locked, out_rst_n}, expv());
    end
    write(2'd1, 8'h40, 8'h10);
    w = edge_n;
    n_cmp++;
    if ({locked, out_rst_n} !== 2'b00) begin
      n_fail++;
      $display("FAIL cfg_drop: locked/out_rst_n %b want 00", {locked, out_rst_n});
    end
    fl = -1; fr = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if ({ce_out, clk_lvl, locked, out_rst_n} !== expv()) begin
        n_fail++;
        $display("FAIL relock edge %0d: got %b want %b", edge_n, {ce_out, clk_lvl, locked, out_rst_n}, expv());
      end
      if (locked && fl < 0) fl = edge_n - w;
      if (out_rst_n && fr < 0) fr = edge_n - w;
    end
    n_cmp++;
    if (fl != LC || fr != LC + RH) begin
      n_fail++;
      $display("FAIL relock_timing: lock %0d run %0d want %0d %0d", fl, fr, LC, LC + RH);
    end
    guard = 0;
    while (m_acc[0] + m_inc[0] < 256 && guard < 8) begin tick(); guard++; end
    write(2'd0, 8'h55, 8'h00);
    n_cmp++;
    if (ce_out[0] !== 1'b0 || {ce_out, clk_lvl, locked, out_rst_n} !== expv()) begin
      n_fail++;
      $display("FAIL wr_on_overflow: got %b want %b", {ce_out, clk_lvl, locked, out_rst_n}, expv());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      ch_en = 2'($urandom_range(0, 3) != 0 ? 3 : $urandom_range(0, 3));
      cfg_wr = ($urandom_range(0, 39) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_inc = 8'($urandom);
      cfg_phase = 8'($urandom);
      tick();
      n_cmp++;
      if ({ce_out, clk_lvl, locked, out_rst_n} !== expv()) begin
        n_fail++;
        $display("FAIL random edge %0d: got %b want %b", edge_n, {ce_out, clk_lvl, locked, out_rst_n}, expv());
      end
    end
    cfg_wr = 1'b0;
    ch_en = 2'b11;
  endtask

  task automatic test_async_reset();
    write(2'd0, 8'h80, 8'h00);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ce_out, clk_lvl, locked, out_rst_n} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 000000", {ce_out, clk_lvl, locked, out_rst_n});
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (ce_out !== 2'b00 || {ce_out, clk_lvl, locked, out_rst_n} !== expv()) begin
        n_fail++;
        $display("FAIL post_reset edge %0d: got %b want %b", edge_n, {ce_out, clk_lvl, locked, out_rst_n}, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_phase();
    test_rate();
    test_enable();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
